// File: rtl/mm_pkg.sv
// Shared types and constants for the tiled matrix-multiply datapath control.
// The scheduler, its loop counter and the bench all pull their widths from here.
package mm_pkg;

    localparam int T          = 4;
    localparam int MAX_TILES  = 8;
    localparam int TILE_IDX_W = $clog2(MAX_TILES);

    typedef logic [TILE_IDX_W-1:0] tile_idx_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_PE = 3'd3,
        S_WB      = 3'd4,
        S_NEXT    = 3'd5,
        S_FIN     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/mm_tile_counter.sv
// Three-level nested wrap counter walking (i, j, k) with k innermost.
// Limits are latched on load so the caller may change its config inputs mid-job.
module mm_tile_counter #(
    parameter int IDX_W = mm_pkg::TILE_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    input  logic [IDX_W:0]   m_dim,
    input  logic [IDX_W:0]   n_dim,
    input  logic [IDX_W:0]   k_dim,
    output logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] j_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             last
);

    logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [IDX_W-1:0] i_lim_q, i_lim_d, j_lim_q, j_lim_d, k_lim_q, k_lim_d;
    logic [IDX_W:0]   m_m1, n_m1, k_m1;

    // Dimensions are 1..MAX_TILES, so dim-1 always fits in an index.
    assign m_m1 = m_dim - 1'b1;
    assign n_m1 = n_dim - 1'b1;
    assign k_m1 = k_dim - 1'b1;

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        i_lim_d = i_lim_q;
        j_lim_d = j_lim_q;
        k_lim_d = k_lim_q;
        if (load) begin
            i_lim_d = m_m1[IDX_W-1:0];
            j_lim_d = n_m1[IDX_W-1:0];
            k_lim_d = k_m1[IDX_W-1:0];
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end else if (adv) begin
            if (k_q != k_lim_q) begin
                k_d = k_q + 1'b1;
            end else begin
                k_d = '0;
                if (j_q != j_lim_q) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    if (i_q != i_lim_q) begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            i_lim_q <= '0;
            j_lim_q <= '0;
            k_lim_q <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            i_lim_q <= i_lim_d;
            j_lim_q <= j_lim_d;
            k_lim_q <= k_lim_d;
        end
    end

    assign i_idx = i_q;
    assign j_idx = j_q;
    assign k_idx = k_q;
    assign last  = (k_q == k_lim_q) && (j_q == j_lim_q) && (i_q == i_lim_q);

endmodule

// File: rtl/mm_tile_scheduler.sv
// Walks every (i, j, k) tile step of C = A*B: load A(i,k)/B(k,j), run the PE
// array once, then write back / accumulate into C(i,j). PE hangs abort the job.
module mm_tile_scheduler #(
    parameter int MAX_TILES = mm_pkg::MAX_TILES,
    parameter int IDX_W     = $clog2(MAX_TILES),
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [IDX_W:0]         cfg_m_tiles,
    input  logic [IDX_W:0]         cfg_n_tiles,
    input  logic [IDX_W:0]         cfg_k_tiles,
    output logic                   cfg_err,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   ld_req,
    input  logic                   ld_ack,
    output logic [IDX_W-1:0]       ld_i,
    output logic [IDX_W-1:0]       ld_j,
    output logic [IDX_W-1:0]       ld_k,
    output logic                   pe_start,
    input  logic                   pe_done,
    output logic                   wb_req,
    input  logic                   wb_ack,
    output logic [IDX_W-1:0]       wb_i,
    output logic [IDX_W-1:0]       wb_j,
    output logic                   wb_accum,
    output mm_pkg::sched_state_t   dbg_state
);

    import mm_pkg::*;

    // Handshakes: ld_req / wb_req rise when their state is entered and stay
    // high with stable indices until the matching ack is sampled high on a
    // clock edge; an ack arriving in the same cycle the request rises counts.
    // Acks and pe_done seen in any other state are dropped.

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]  DIM_MAX  = (IDX_W + 1)'(MAX_TILES);

    sched_state_t    state_q, state_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            cfg_err_q, cfg_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_err_q, timeout_err_d;
    logic            ld_req_q, ld_req_d;
    logic            pe_start_q, pe_start_d;
    logic            wb_req_q, wb_req_d;
    logic            wb_accum_q, wb_accum_d;

    logic             cfg_ok;
    logic             cnt_load, cnt_adv, cnt_last;
    logic [IDX_W-1:0] cnt_i, cnt_j, cnt_k;

    assign cfg_ok = (cfg_m_tiles != '0) && (cfg_m_tiles <= DIM_MAX) &&
                    (cfg_n_tiles != '0) && (cfg_n_tiles <= DIM_MAX) &&
                    (cfg_k_tiles != '0) && (cfg_k_tiles <= DIM_MAX);

    mm_tile_counter #(
        .IDX_W (IDX_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .adv   (cnt_adv),
        .m_dim (cfg_m_tiles),
        .n_dim (cfg_n_tiles),
        .k_dim (cfg_k_tiles),
        .i_idx (cnt_i),
        .j_idx (cnt_j),
        .k_idx (cnt_k),
        .last  (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        cfg_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        cnt_load      = 1'b0;
        cnt_adv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        cnt_load      = 1'b1;
                        timeout_err_d = 1'b0;
                        state_d       = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ld_ack) state_d = S_START;
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT_PE;
            end
            S_WAIT_PE: begin
                // Compare the incremented count so done lands TIMEOUT cycles after pe_start.
                wdog_d = wdog_q + 1'b1;
                if (pe_done) begin
                    state_d = S_WB;
                end else if (wdog_d == WD_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FIN;
                end
            end
            S_WB: begin
                if (wb_ack) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (cnt_last) begin
                    state_d = S_FIN;
                end else begin
                    cnt_adv = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are valid on entry.
        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d      = (state_d == S_FIN);
        ld_req_d    = (state_d == S_LOAD);
        pe_start_d  = (state_d == S_START);
        wb_req_d    = (state_d == S_WB);
        wb_accum_d  = (state_d == S_WB) && (cnt_k != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wdog_q        <= '0;
            cfg_ready_q   <= 1'b1;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            ld_req_q      <= 1'b0;
            pe_start_q    <= 1'b0;
            wb_req_q      <= 1'b0;
            wb_accum_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            ld_req_q      <= ld_req_d;
            pe_start_q    <= pe_start_d;
            wb_req_q      <= wb_req_d;
            wb_accum_q    <= wb_accum_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign ld_req      = ld_req_q;
    assign pe_start    = pe_start_q;
    assign wb_req      = wb_req_q;
    assign wb_accum    = wb_accum_q;
    assign ld_i        = cnt_i;
    assign ld_j        = cnt_j;
    assign ld_k        = cnt_k;
    assign wb_i        = cnt_i;
    assign wb_j        = cnt_j;
    assign dbg_state   = state_q;

endmodule
